// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, 1-entry skid buffer, IF/ID register.
// Define FETCH_PERF_COUNTERS_EN to build the fetch/bubble performance counters.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_src,
  input  logic [DATA_WIDTH-1:0] pc_target_e,
  input  logic                  stall_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] ins,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus_4d,
  output logic                  valid_d,
  output logic [31:0]           fetch_count,
  output logic [31:0]           bubble_count
);

  localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] pc_f;
  logic [DATA_WIDTH-1:0] target_aligned;
  logic                  accept;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_ins;
  logic [DATA_WIDTH-1:0] skid_pc;

  assign target_aligned = pc_target_e & ~DATA_WIDTH'(3);

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (imem_req) state_next = WAIT;
      WAIT: begin
        if (imem_valid)  state_next = FETCH;
        else if (pc_src) state_next = DROP;
      end
      DROP:    if (imem_valid) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // A redirect wins over everything; a full skid buffer means decode has not taken the last word yet.
  always_comb begin
    imem_req  = !rst && (state == FETCH) && !pc_src && !stall_f && !skid_valid;
    imem_addr = pc_f;
    accept    = (state == WAIT) && imem_valid && !pc_src;
  end

  always_ff @(posedge clk) begin
    if (rst)         pc_f <= RESET_PC;
    else if (pc_src) pc_f <= target_aligned;
    else if (accept) pc_f <= pc_f + FOUR;
  end

  // Flush beats stall and load; a redirect makes any buffered word wrong-path.
  always_ff @(posedge clk) begin
    if (rst) begin
      ins        <= NOP;
      pc_d       <= '0;
      pc_plus_4d <= '0;
      valid_d    <= 1'b0;
      skid_valid <= 1'b0;
      skid_ins   <= '0;
      skid_pc    <= '0;
    end else if (flush_d) begin
      ins        <= NOP;
      valid_d    <= 1'b0;
      skid_valid <= 1'b0;
    end else if (stall_d) begin
      if (pc_src) begin
        skid_valid <= 1'b0;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_ins   <= imem_rdata;
        skid_pc    <= pc_f;
      end
    end else begin
      skid_valid <= 1'b0;
      if (skid_valid && !pc_src) begin
        ins        <= skid_ins;
        pc_d       <= skid_pc;
        pc_plus_4d <= skid_pc + FOUR;
        valid_d    <= 1'b1;
      end else if (accept) begin
        ins        <= imem_rdata;
        pc_d       <= pc_f;
        pc_plus_4d <= pc_f + FOUR;
        valid_d    <= 1'b1;
      end else begin
        ins        <= NOP;
        valid_d    <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
  logic        load_bubble;

  assign load_bubble = !flush_d && !stall_d && !(skid_valid && !pc_src) && !accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (accept)      fetch_cnt  <= fetch_cnt + 32'd1;
      if (load_bubble) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt;
  assign bubble_count = bubble_cnt;
`else
  assign fetch_count  = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural imem with variable latency feeds the DUT and
// a queue of expected IF/ID words is compared when decode takes them.
module tb_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src;
  logic [31:0] pc_target_e;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] pc_d;
  logic [31:0] pc_plus_4d;
  logic        valid_d;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_src       (pc_src),
    .pc_target_e  (pc_target_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .ins          (ins),
    .pc_d         (pc_d),
    .pc_plus_4d   (pc_plus_4d),
    .valid_d      (valid_d),
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_addr;
  bit          pending;
  bit          kept;
  int          cd;
  int          mem_lat = 1;
  logic [31:0] pend_addr;
  int          model_fetches;
  int          model_bubbles;
  logic [31:0] prev_ins;
  logic [31:0] prev_pc;
  logic        prev_valid;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1; pc_src = 1'b0; pc_target_e = '0; stall_f = 1'b0; stall_d = 1'b0;
    flush_d = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    pending = 0; kept = 0; sb.delete(); exp_addr = RESET_PC;
    model_fetches = 0; model_bubbles = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ins", ins, NOP);
    checkOutput("rst_pc_d", pc_d, 32'h0);
    checkOutput("rst_pc_plus_4d", pc_plus_4d, 32'h0);
    checkOutput("rst_valid_d", 32'(valid_d), 32'h0);
    checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
    checkOutput("rst_fetch_count", fetch_count, 32'h0);
    checkOutput("rst_bubble_count", bubble_count, 32'h0);
    prev_ins = NOP; prev_pc = '0; prev_valid = 1'b0;
    rst = 1'b0;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic applyStimulus(input logic src, input logic [31:0] tgt, input logic sf,
                               input logic sd, input logic fl);
    bit     delivering;
    bit     skid_full;
    bit     outstanding;
    bit     exp_req;
    entry_t e;
    pc_src = src; pc_target_e = tgt; stall_f = sf; stall_d = sd; flush_d = fl;
    skid_full   = sb.size() > 0;
    outstanding = pending;
    delivering  = 0;
    imem_valid  = 1'b0;
    imem_rdata  = $urandom;
    if (pending) begin
      cd--;
      if (cd == 0) begin
        delivering = 1;
        imem_valid = 1'b1;
        imem_rdata = memData(pend_addr);
      end
    end
    if (src) begin
      kept = 0;
      exp_addr = tgt & ~32'h3;
    end
    if (delivering) begin
      pending = 0;
      if (kept) begin
        sb.push_back('{pc: pend_addr, word: memData(pend_addr)});
        exp_addr = pend_addr + 32'd4;
        model_fetches++;
      end
    end
    if (src || fl) sb.delete();
    exp_req = !outstanding && !src && !sf && !skid_full;
    #1;
    checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
    if (imem_req && exp_req) begin
      checkOutput("imem_addr", imem_addr, exp_addr);
      pending = 1; kept = 1; cd = mem_lat; pend_addr = exp_addr;
    end
    @(posedge clk);
    @(negedge clk);
    if (fl) begin
      checkOutput("flush_valid_d", 32'(valid_d), 32'h0);
      checkOutput("flush_ins", ins, NOP);
    end else if (sd) begin
      checkOutput("hold_valid_d", 32'(valid_d), 32'(prev_valid));
      checkOutput("hold_pc_d", pc_d, prev_pc);
      checkOutput("hold_ins", ins, prev_ins);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("load_valid_d", 32'(valid_d), 32'h1);
      checkOutput("load_pc_d", pc_d, e.pc);
      checkOutput("load_ins", ins, e.word);
      checkOutput("load_pc_plus_4d", pc_plus_4d, e.pc + 32'd4);
    end else begin
      checkOutput("bubble_valid_d", 32'(valid_d), 32'h0);
      checkOutput("bubble_ins", ins, NOP);
      model_bubbles++;
    end
    prev_ins = ins; prev_pc = pc_d; prev_valid = valid_d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitFreshIssue();
    for (int i = 0; i < 20 && pending; i++) idle(1);
    for (int i = 0; i < 20 && !pending; i++) idle(1);
    checkOutput("issue_wait", 32'(pending), 32'h1);
  endtask

  task automatic waitIssueAt(input logic [31:0] addr);
    for (int i = 0; i < 30 && !(pending && pend_addr == addr); i++) idle(1);
    checkOutput("issue_at_wait", 32'(pending && pend_addr == addr), 32'h1);
  endtask

  task automatic checkCounters(input string tag);
`ifdef FETCH_PERF_COUNTERS_EN
    checkOutput({tag, "_fetch_count"}, fetch_count, 32'(model_fetches));
    checkOutput({tag, "_bubble_count"}, bubble_count, 32'(model_bubbles));
`else
    checkOutput({tag, "_fetch_count"}, fetch_count, 32'h0);
    checkOutput({tag, "_bubble_count"}, bubble_count, 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; pc_src = 1'b0; pc_target_e = '0; stall_f = 1'b0; stall_d = 1'b0;
    flush_d = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    applyReset();

    // Latency-1 streaming straight out of reset.
    mem_lat = 1;
    idle(24);
    checkCounters("stream");

    // Redirect while waiting; late response must be dropped.
    mem_lat = 3;
    waitFreshIssue();
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Redirect in the same cycle as the response, unaligned target.
    mem_lat = 2;
    waitFreshIssue();
    idle(1);
    applyStimulus(1'b1, 32'h0000_0043, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Decode stall while the word at 0x8 returns.
    applyReset();
    mem_lat = 1;
    waitIssueAt(32'h0000_0008);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Flush with a full skid buffer and stall_d asserted.
    waitFreshIssue();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(3);

    // Fetch stall, redirect past the stall, and PC wrap at the top of memory.
    for (int i = 0; i < 20 && pending; i++) idle(1);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Reset while a request is outstanding.
    mem_lat = 3;
    waitFreshIssue();
    applyReset();
    mem_lat = 1;
    idle(6);

    // Randomised mix of latencies, stalls, flushes and redirects.
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(1, 3);
      applyStimulus(($urandom_range(0, 9) == 0),
                    {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_empty", 32'(sb.size()), 32'h0);
    checkCounters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
